// File: rtl/bus_arbiter_pkg.sv
// Shared types for the coherence-bus arbiter: request classes and FSM states.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    BREQ_NONE = 2'd0,
    BREQ_WB   = 2'd1,
    BREQ_CC   = 2'd2,
    BREQ_I    = 2'd3
  } bus_req_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Highest class a single core is asking for (WB > CC > I).
  function automatic bus_req_t top_class(input logic wb, input logic cc, input logic ir);
    if (wb)      return BREQ_WB;
    else if (cc) return BREQ_CC;
    else if (ir) return BREQ_I;
    else         return BREQ_NONE;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin finder: first set bit of req scanning upward from start, modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0] rot;
  int           sum;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    // Rotate so bit 0 is the core at start; the lowest set bit is then the winner.
    rot   = N'({req, req} >> start);
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        sum   = int'(start) + j;
        if (sum >= N) sum = sum - N;
        idx   = IW'(sum);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Coherence bus arbiter: class priority WB > CC > I, round-robin within a class,
// per-core aging that overrides class priority once a core has waited AGE_MAX cycles.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NCORES  = 2,
  parameter int AGE_MAX = 15,
  parameter int AGE_W   = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NCORES-1:0]         wb_req,
  input  logic [NCORES-1:0]         cc_req,
  input  logic [NCORES-1:0]         i_req,
  input  logic                      txn_done,
  output logic                      grant_valid,
  output logic [$clog2(NCORES)-1:0] grant_core,
  output bus_req_t                  grant_type,
  output logic                      aborted,
  output logic [NCORES-1:0]         starve
);

  localparam int CW = $clog2(NCORES);

  arb_state_t        state;
  logic [CW-1:0]     rr_ptr;
  logic [AGE_W-1:0]  age     [NCORES];
  logic [AGE_W-1:0]  age_nxt [NCORES];
  logic [NCORES-1:0] starve_nxt;
  logic [NCORES-1:0] any_req;
  logic [NCORES-1:0] starve_req;

  logic              wb_found, cc_found, i_found, sv_found;
  logic [CW-1:0]     wb_idx, cc_idx, i_idx, sv_idx;

  logic              win_found;
  logic [CW-1:0]     win_core;
  bus_req_t          win_type;
  logic [CW-1:0]     ptr_nxt;
  logic              grant_req;

  assign any_req    = wb_req | cc_req | i_req;
  // A starved core that has since dropped all requests has nothing to be granted.
  assign starve_req = starve & any_req;

  rr_pick #(.N(NCORES), .IW(CW)) u_pick_wb (.req(wb_req),     .start(rr_ptr), .found(wb_found), .idx(wb_idx));
  rr_pick #(.N(NCORES), .IW(CW)) u_pick_cc (.req(cc_req),     .start(rr_ptr), .found(cc_found), .idx(cc_idx));
  rr_pick #(.N(NCORES), .IW(CW)) u_pick_i  (.req(i_req),      .start(rr_ptr), .found(i_found),  .idx(i_idx));
  rr_pick #(.N(NCORES), .IW(CW)) u_pick_sv (.req(starve_req), .start(rr_ptr), .found(sv_found), .idx(sv_idx));

  always_comb begin
    win_found = 1'b0;
    win_core  = '0;
    win_type  = BREQ_NONE;
    if (sv_found) begin
      win_found = 1'b1;
      win_core  = sv_idx;
      win_type  = top_class(wb_req[sv_idx], cc_req[sv_idx], i_req[sv_idx]);
    end else if (wb_found) begin
      win_found = 1'b1;
      win_core  = wb_idx;
      win_type  = BREQ_WB;
    end else if (cc_found) begin
      win_found = 1'b1;
      win_core  = cc_idx;
      win_type  = BREQ_CC;
    end else if (i_found) begin
      win_found = 1'b1;
      win_core  = i_idx;
      win_type  = BREQ_I;
    end
  end

  assign ptr_nxt = (win_core == CW'(NCORES - 1)) ? '0 : win_core + 1'b1;

  always_comb begin
    case (grant_type)
      BREQ_WB: grant_req = wb_req[grant_core];
      BREQ_CC: grant_req = cc_req[grant_core];
      BREQ_I:  grant_req = i_req[grant_core];
      default: grant_req = 1'b0;
    endcase
  end

  always_comb begin
    starve_nxt = '0;
    for (int k = 0; k < NCORES; k++) begin
      age_nxt[k] = age[k];
      if (!any_req[k]
          || (state == ARB_GRANT && grant_core == CW'(k))
          || (state == ARB_IDLE && win_found && win_core == CW'(k)))
        age_nxt[k] = '0;
      else if (age[k] != AGE_W'(AGE_MAX))
        age_nxt[k] = age[k] + 1'b1;
      starve_nxt[k] = (age_nxt[k] == AGE_W'(AGE_MAX));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ARB_IDLE;
      grant_valid <= 1'b0;
      grant_core  <= '0;
      grant_type  <= BREQ_NONE;
      aborted     <= 1'b0;
      rr_ptr      <= '0;
      starve      <= '0;
      for (int k = 0; k < NCORES; k++) age[k] <= '0;
    end else begin
      for (int k = 0; k < NCORES; k++) age[k] <= age_nxt[k];
      starve  <= starve_nxt;
      aborted <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (win_found) begin
            state       <= ARB_GRANT;
            grant_valid <= 1'b1;
            grant_core  <= win_core;
            grant_type  <= win_type;
            rr_ptr      <= ptr_nxt;
          end
        end
        ARB_GRANT: begin
          // Completion outranks a same-cycle request drop; either forces an idle bubble.
          if (txn_done) begin
            state       <= ARB_IDLE;
            grant_valid <= 1'b0;
          end else if (!grant_req) begin
            state       <= ARB_IDLE;
            grant_valid <= 1'b0;
            aborted     <= 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios plus randomized traffic.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int N    = 2;
  localparam int AMAX = 15;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] wb_req = '0, cc_req = '0, i_req = '0;
  logic       txn_done = 1'b0;
  logic       grant_valid;
  logic [0:0] grant_core;
  bus_req_t   grant_type;
  logic       aborted;
  logic [1:0] starve;

  bus_arbiter #(.NCORES(N), .AGE_MAX(AMAX), .AGE_W(4)) dut (
    .CLK(CLK), .RST(RST), .wb_req(wb_req), .cc_req(cc_req), .i_req(i_req),
    .txn_done(txn_done), .grant_valid(grant_valid), .grant_core(grant_core),
    .grant_type(grant_type), .aborted(aborted), .starve(starve)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int gv;
    int core;
    int typ;
    int ab;
    int stv;
  } exp_t;

  exp_t expq[$];
  int   glog[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: grant owner, waiting time per core, shared pointer.
  int m_gv = 0, m_core = 0, m_typ = 0, m_ab = 0, m_ptr = 0, m_hold = 0;
  int m_age[N];

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic bit reqbit(input int cls, input int k,
                                input logic [1:0] w, input logic [1:0] c, input logic [1:0] ii);
    case (cls)
      1:       return w[k];
      2:       return c[k];
      3:       return ii[k];
      default: return 1'b0;
    endcase
  endfunction

  function automatic int glog_at(input int i);
    if (i < glog.size()) return glog[i];
    return -1;
  endfunction

  task automatic model_step(input logic [1:0] w, input logic [1:0] c, input logic [1:0] ii,
                            input bit done, input bit rst);
    int   new_age[N];
    int   win, wtyp, k, anyk;
    exp_t e;
    if (rst) begin
      m_gv = 0; m_core = 0; m_typ = 0; m_ab = 0; m_ptr = 0; m_hold = 0;
      for (int q = 0; q < N; q++) m_age[q] = 0;
    end else begin
      win = -1;
      wtyp = 0;
      if (m_gv == 0) begin
        for (int j = 0; j < N; j++) begin
          k = (m_ptr + j) % N;
          if (win < 0 && m_age[k] == AMAX && (w[k] | c[k] | ii[k])) begin
            win  = k;
            wtyp = w[k] ? 1 : (c[k] ? 2 : 3);
          end
        end
        for (int cls = 1; cls <= 3; cls++)
          for (int j = 0; j < N; j++) begin
            k = (m_ptr + j) % N;
            if (win < 0 && reqbit(cls, k, w, c, ii)) begin
              win  = k;
              wtyp = cls;
            end
          end
      end
      for (int q = 0; q < N; q++) begin
        anyk = int'(w[q] | c[q] | ii[q]);
        if (anyk == 0 || (m_gv == 1 && m_core == q) || win == q) new_age[q] = 0;
        else new_age[q] = (m_age[q] + 1 > AMAX) ? AMAX : m_age[q] + 1;
      end
      m_ab = 0;
      if (win >= 0) begin
        m_gv = 1; m_core = win; m_typ = wtyp; m_ptr = (win + 1) % N; m_hold = 0;
      end else if (m_gv == 1) begin
        if (done) m_gv = 0;
        else if (!reqbit(m_typ, m_core, w, c, ii)) begin
          m_gv = 0;
          m_ab = 1;
        end else m_hold++;
      end
      for (int q = 0; q < N; q++) m_age[q] = new_age[q];
    end
    e.gv = m_gv; e.core = m_core; e.typ = m_typ; e.ab = m_ab; e.stv = 0;
    for (int q = 0; q < N; q++) if (m_age[q] == AMAX) e.stv = e.stv | (1 << q);
    expq.push_back(e);
  endtask

  // One bus cycle: drive at negedge, predict, return after the monitor has sampled.
  task automatic cycle(input logic [1:0] w, input logic [1:0] c, input logic [1:0] ii,
                       input bit done, input bit rst);
    @(negedge CLK);
    wb_req = w; cc_req = c; i_req = ii; txn_done = done; RST = rst;
    model_step(w, c, ii, done, rst);
    @(posedge CLK);
    #2;
  endtask

  task automatic rstc(input int n);
    for (int r = 0; r < n; r++) cycle(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
  endtask

  exp_t e_mon;
  bit   prev_gv = 1'b0;

  always @(posedge CLK) begin
    #1;
    if (expq.size() > 0) begin
      e_mon = expq.pop_front();
      chk("grant_valid", int'(grant_valid), e_mon.gv);
      if (e_mon.gv != 0) begin
        chk("grant_core", int'(grant_core), e_mon.core);
        chk("grant_type", int'(grant_type), e_mon.typ);
      end
      chk("aborted", int'(aborted), e_mon.ab);
      chk("starve", int'(starve), e_mon.stv);
    end
    if (grant_valid && !prev_gv) glog.push_back(int'(grant_core) * 4 + int'(grant_type));
    prev_gv = grant_valid;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] rw, rc, ri;
    int         n_idle;

    // Reset held with every request high, then first grant one cycle later.
    glog.delete();
    cycle(2'b11, 2'b11, 2'b11, 1'b0, 1'b1);
    cycle(2'b11, 2'b11, 2'b11, 1'b0, 1'b1);
    chk("t1_no_grant_in_reset", glog.size(), 0);
    cycle(2'b11, 2'b11, 2'b11, 1'b0, 1'b0);
    chk("t1_first_grant", glog_at(0), 0 * 4 + 1);

    // Class priority, then the lower class after the idle bubble.
    rstc(1);
    glog.delete();
    cycle(2'b10, 2'b00, 2'b01, 1'b0, 1'b0);
    cycle(2'b10, 2'b00, 2'b01, 1'b0, 1'b0);
    cycle(2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
    cycle(2'b00, 2'b00, 2'b01, 1'b0, 1'b0);
    cycle(2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    chk("t2_wb_first", glog_at(0), 1 * 4 + 1);
    chk("t2_i_second", glog_at(1), 0 * 4 + 3);

    // Round-robin inside one class.
    rstc(1);
    glog.delete();
    for (int c = 0; c < 12; c++)
      cycle(2'b00, 2'b11, 2'b00, (m_gv == 1 && m_hold >= 2), 1'b0);
    chk("t3_grant_count", glog.size(), 3);
    chk("t3_rr0", glog_at(0), 0 * 4 + 2);
    chk("t3_rr1", glog_at(1), 1 * 4 + 2);
    chk("t3_rr2", glog_at(2), 0 * 4 + 2);

    // Starvation: core1 icache overrides core0's steady writebacks.
    rstc(1);
    glog.delete();
    for (int c = 0; c < 40; c++)
      cycle(2'b01, 2'b00, 2'b10, (m_gv == 1 && m_hold >= 1), 1'b0);
    chk("t4_wb_before", glog_at(4), 0 * 4 + 1);
    chk("t4_starved_served", glog_at(5), 1 * 4 + 3);

    // Abort on request drop, then normal arbitration.
    rstc(1);
    glog.delete();
    cycle(2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
    cycle(2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
    cycle(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    chk("t5_aborted_pulse", int'(aborted), 1);
    cycle(2'b00, 2'b00, 2'b10, 1'b0, 1'b0);
    chk("t5_aborted_clear", int'(aborted), 0);
    cycle(2'b00, 2'b00, 2'b10, 1'b1, 1'b0);
    chk("t5_cc_grant", glog_at(0), 0 * 4 + 2);
    chk("t5_next_grant", glog_at(1), 1 * 4 + 3);

    // Reset while granted clears the grant and the pointer.
    rstc(1);
    glog.delete();
    cycle(2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
    cycle(2'b00, 2'b11, 2'b00, 1'b0, 1'b1);
    chk("t6_grant_dropped", int'(grant_valid), 0);
    cycle(2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    cycle(2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
    cycle(2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
    chk("t6_grant_count", glog.size(), 2);
    chk("t6_ptr_reset", glog_at(1), 0 * 4 + 2);

    // Randomized traffic with sticky requests and occasional reset.
    rstc(1);
    rw = '0; rc = '0; ri = '0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) rw[k] = ~rw[k];
        if ($urandom_range(0, 3) == 0) rc[k] = ~rc[k];
        if ($urandom_range(0, 3) == 0) ri[k] = ~ri[k];
      end
      cycle(rw, rc, ri, (m_gv == 1 && $urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
    end
    cycle(2'b00, 2'b00, 2'b00, 1'b1, 1'b0);

    n_idle = 0;
    while (expq.size() > 0 && n_idle < 5) begin
      @(posedge CLK);
      #2;
      n_idle++;
    end
    chk("scoreboard_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
